// File: rtl/fetch_pkg.sv
// Shared types for pixel_fetch: FSM encoding, tag FIFO entry, default depth.
// The tag coordinate fields are sized for the largest supported image.
package fetch_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int TAG_CW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN
    } state_e;

    typedef struct packed {
        logic [TAG_CW-1:0] x;
        logic [TAG_CW-1:0] y;
        logic              last;
    } tag_t;

    function automatic tag_t make_tag(
        input logic [TAG_CW-1:0] x,
        input logic [TAG_CW-1:0] y,
        input logic              last
    );
        tag_t t;
        t.x    = x;
        t.y    = y;
        t.last = last;
        return t;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read port.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
        if (do_push && !do_pop) cnt_d = cnt_q + CNT_ONE;
        else if (do_pop && !do_push) cnt_d = cnt_q - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/pixel_fetch.sv
// Frame pixel fetcher: issues raster reads, pairs returns with their positions.
// Optional statistics counters are built with PIXEL_FETCH_STATS_EN defined.
module pixel_fetch
    import fetch_pkg::*;
#(
    parameter int X_MAX  = 64,
    parameter int Y_MAX  = 64,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int XW    = $clog2(X_MAX),
    localparam int YW    = $clog2(Y_MAX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [XW-1:0]     img_w,
    input  logic [YW-1:0]     img_h,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [XW-1:0]     curr_x,
    input  logic [YW-1:0]     curr_y,
    input  logic              end_pos,
    output logic              update_pos,
    output logic              new_trans,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [DATA_W-1:0] px_data,
    output logic [XW-1:0]     px_x,
    output logic [YW-1:0]     px_y,
    output logic              px_last,
    output logic              busy,
    output logic              done
`ifdef PIXEL_FETCH_STATS_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       bp_cycles
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [XW-1:0]     w_q, w_d;
    logic              start_acc;
    logic              grant;
    logic              px_fire;
    logic [ADDR_W-1:0] addr_calc;
    tag_t              tag_wr, tag_rd;
    logic              tag_full, tag_empty;
    logic              dat_full, dat_empty;
    logic [CW-1:0]     tag_cnt, dat_cnt;
    logic [DATA_W-1:0] dat_rd;
    logic              dat_push;
    logic              unused_sig;

    assign start_acc = (state_q == ST_IDLE) && start;
    assign grant     = mem_req && mem_gnt;
    assign busy      = (state_q != ST_IDLE);

    // The full product is kept to ADDR_W bits; overflow wraps by design.
    assign addr_calc = base_q
                     + ADDR_W'(curr_y) * ADDR_W'(w_q)
                     + ADDR_W'(curr_x);
    assign mem_addr  = (state_q == ST_ISSUE) ? addr_calc : '0;

    always_comb begin
        base_d = base_q;
        w_d    = w_q;
        if (start_acc) begin
            base_d = base_addr;
            w_d    = img_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            w_q     <= w_d;
        end
    end

    // A pop frees its credit in the same cycle, so a full tag FIFO can still grant.
    always_comb begin
        state_d    = state_q;
        new_trans  = 1'b0;
        mem_req    = 1'b0;
        update_pos = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                new_trans = 1'b1;
                state_d   = ST_ISSUE;
            end
            ST_ISSUE: begin
                mem_req = !tag_full || px_fire;
                if (mem_req && mem_gnt) begin
                    if (end_pos) state_d = ST_DRAIN;
                    else update_pos = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (px_fire && px_last) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign tag_wr = make_tag(TAG_CW'(curr_x), TAG_CW'(curr_y), end_pos);

    sync_fifo #(
        .WIDTH ($bits(tag_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .wdata (tag_wr),
        .pop   (px_fire),
        .rdata (tag_rd),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

    // Returns landing while idle belong to an aborted frame and are dropped.
    assign dat_push = mem_rvalid && busy;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_dat_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (dat_push),
        .wdata (mem_rdata),
        .pop   (px_fire),
        .rdata (dat_rd),
        .full  (dat_full),
        .empty (dat_empty),
        .count (dat_cnt)
    );

    assign px_valid = !dat_empty;
    assign px_fire  = px_valid && px_ready;
    assign px_data  = px_valid ? dat_rd : '0;
    assign px_x     = px_valid ? tag_rd.x[XW-1:0] : '0;
    assign px_y     = px_valid ? tag_rd.y[YW-1:0] : '0;
    assign px_last  = px_valid && tag_rd.last;

    assign unused_sig = ^{img_h, tag_rd, tag_empty, tag_cnt, dat_full, dat_cnt};

`ifdef PIXEL_FETCH_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] bp_q, bp_d;

    always_comb begin
        stall_d = stall_q;
        bp_d    = bp_q;
        if (start_acc) begin
            stall_d = '0;
            bp_d    = '0;
        end else begin
            if ((state_q == ST_ISSUE) && mem_req && !mem_gnt
                && (stall_q != 16'hFFFF))
                stall_d = stall_q + 16'd1;
            if (px_valid && !px_ready && (bp_q != 16'hFFFF))
                bp_d = bp_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            bp_q    <= '0;
        end else begin
            stall_q <= stall_d;
            bp_q    <= bp_d;
        end
    end

    assign stall_cycles = stall_q;
    assign bp_cycles    = bp_q;
`endif

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch with a raster position generator and memory.
// Build with PIXEL_FETCH_STATS_EN to also exercise the statistics counters.
module tb_pixel_fetch;
    import fetch_pkg::*;

    localparam int XW = 6;
    localparam int YW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [XW-1:0] img_w = '0;
    logic [YW-1:0] img_h = '0;
    logic [15:0]   base_addr = '0;
    logic [XW-1:0] curr_x;
    logic [YW-1:0] curr_y;
    logic          end_pos;
    logic          update_pos, new_trans;
    logic          mem_req;
    logic [15:0]   mem_addr;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid;
    logic [7:0]    mem_rdata;
    logic          px_valid;
    logic          px_ready = 1'b0;
    logic [7:0]    px_data;
    logic [XW-1:0] px_x;
    logic [YW-1:0] px_y;
    logic          px_last, busy, done;
`ifdef PIXEL_FETCH_STATS_EN
    logic [15:0]   stall_cycles, bp_cycles;
`endif

    always #5 clk = ~clk;

    pixel_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .img_w      (img_w),
        .img_h      (img_h),
        .base_addr  (base_addr),
        .curr_x     (curr_x),
        .curr_y     (curr_y),
        .end_pos    (end_pos),
        .update_pos (update_pos),
        .new_trans  (new_trans),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_last    (px_last),
        .busy       (busy),
`ifdef PIXEL_FETCH_STATS_EN
        .stall_cycles (stall_cycles),
        .bp_cycles    (bp_cycles),
`endif
        .done       (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] dat_of(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Frame geometry seen by the position generator and the checkers.
    int cur_w = 4, cur_h = 4, cur_base = 0;
    int px_i = 2, py_i = 1;

    always @(posedge clk) begin
        if (new_trans) begin
            px_i <= 0;
            py_i <= 0;
        end else if (update_pos) begin
            if (px_i == cur_w - 1) begin
                px_i <= 0;
                py_i <= py_i + 1;
            end else begin
                px_i <= px_i + 1;
            end
        end
    end

    assign curr_x  = XW'(px_i);
    assign curr_y  = YW'(py_i);
    assign end_pos = (px_i == cur_w - 1) && (py_i == cur_h - 1);

    // Memory answers every grant exactly one cycle later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_rvalid <= mem_req && mem_gnt;
            mem_rdata  <= dat_of(mem_addr);
        end
    end

    int          gnt_cnt, upd_cnt, nt_cnt, pix_cnt, done_cnt;
    logic [15:0] first_addr;
    logic        hold_v = 1'b0;
    logic [20:0] hold_pl;
    int          ex, ey, ea;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (update_pos) upd_cnt++;
            if (new_trans) nt_cnt++;
            if (done) done_cnt++;
            if (mem_req && mem_gnt) begin
                ea = (cur_base + py_i * cur_w + px_i) & 'hFFFF;
                if (gnt_cnt == 0) first_addr = mem_addr;
                chk("mem_addr", 32'(mem_addr), 32'(ea));
                gnt_cnt++;
            end
            if (hold_v)
                chk("px_hold", 32'({px_valid, px_data, px_x, px_y, px_last}),
                    32'({1'b1, hold_pl}));
            hold_v  = px_valid && !px_ready;
            hold_pl = {px_data, px_x, px_y, px_last};
            if (px_valid && px_ready) begin
                ex = pix_cnt % cur_w;
                ey = pix_cnt / cur_w;
                ea = (cur_base + ey * cur_w + ex) & 'hFFFF;
                chk("px_x", 32'(px_x), 32'(ex));
                chk("px_y", 32'(px_y), 32'(ey));
                chk("px_data", 32'(px_data), 32'(dat_of(16'(ea))));
                chk("px_last", 32'(px_last),
                    32'(pix_cnt == cur_w * cur_h - 1));
                chk("done", 32'(done), 32'(px_last));
                pix_cnt++;
            end
        end
    end

    task automatic clr_counts();
        gnt_cnt  = 0;
        upd_cnt  = 0;
        nt_cnt   = 0;
        pix_cnt  = 0;
        done_cnt = 0;
        first_addr = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_frame(input int w, input int h, input int b);
        cur_w     = w;
        cur_h     = h;
        cur_base  = b;
        img_w     = XW'(w);
        img_h     = YW'(h);
        base_addr = 16'(b);
        clr_counts();
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int k = 0;
        while (done_cnt == 0 && k < lim) begin
            cyc(1);
            k++;
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_ctl"}, 32'({mem_req, update_pos, new_trans, px_valid,
                               px_last, busy, done}), 32'd0);
        chk({nm, "_addr"}, 32'(mem_addr), 32'd0);
        chk({nm, "_px"}, 32'({px_data, px_x, px_y}), 32'd0);
    endtask

    typedef struct {
        int w;
        int h;
        int base;
        int exp_pix;
        int exp_upd;
        int exp_first;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{3, 2, 'h100, 6, 5, 'h100};
        vecs[1] = '{1, 1, 'h200, 1, 0, 'h200};
        vecs[2] = '{4, 3, 'h0F0, 12, 11, 'h0F0};
        vecs[3] = '{5, 1, 'h300, 5, 4, 'h300};
        vecs[4] = '{1, 4, 'h040, 4, 3, 'h040};
        clr_counts();

        // Reset with busy-looking stimulus on every input.
        start    = 1'b1;
        mem_gnt  = 1'b1;
        px_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        cyc(1);
        rst   = 1'b0;
        start = 1'b0;
        cyc(1);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            begin_frame(vecs[i].w, vecs[i].h, vecs[i].base);
            wait_done(400);
            chk("frame_pix", 32'(pix_cnt), 32'(vecs[i].exp_pix));
            chk("frame_upd", 32'(upd_cnt), 32'(vecs[i].exp_upd));
            chk("frame_gnt", 32'(gnt_cnt), 32'(vecs[i].exp_pix));
            chk("frame_nt", 32'(nt_cnt), 32'd1);
            chk("frame_first", 32'(first_addr), 32'(vecs[i].exp_first));
            chk("frame_busy", 32'(busy), 32'd0);
        end

        // Credit limit under backpressure, then a single freed credit.
        px_ready = 1'b0;
        begin_frame(4, 2, 'h080);
        cyc(12);
        chk("bp_gnt4", 32'(gnt_cnt), 32'd4);
        chk("bp_req0", 32'(mem_req), 32'd0);
        px_ready = 1'b1;
        cyc(1);
        px_ready = 1'b0;
        cyc(6);
        chk("bp_gnt5", 32'(gnt_cnt), 32'd5);
        chk("bp_req0b", 32'(mem_req), 32'd0);
        chk("bp_pix1", 32'(pix_cnt), 32'd1);
        px_ready = 1'b1;
        wait_done(400);
        chk("bp_pix", 32'(pix_cnt), 32'd8);
        chk("bp_upd", 32'(upd_cnt), 32'd7);

        // Start while draining must be ignored.
        px_ready = 1'b0;
        begin_frame(1, 2, 'h010);
        cyc(8);
        chk("dr_busy", 32'(busy), 32'd1);
        chk("dr_gnt", 32'(gnt_cnt), 32'd2);
        chk("dr_req", 32'(mem_req), 32'd0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        chk("dr_nt", 32'(nt_cnt), 32'd1);
        chk("dr_busy2", 32'(busy), 32'd1);
        px_ready = 1'b1;
        wait_done(400);
        chk("dr_pix", 32'(pix_cnt), 32'd2);
        cyc(3);
        chk("dr_idle", 32'(busy), 32'd0);
        chk("dr_nt2", 32'(nt_cnt), 32'd1);

        // Abort after three grants, then run a clean frame.
        mem_gnt = 1'b0;
        begin_frame(3, 2, 'h100);
        cyc(4);
        mem_gnt = 1'b1;
        cyc(3);
        mem_gnt = 1'b0;
        cyc(1);
        chk("ab_gnt", 32'(gnt_cnt), 32'd3);
        chk("ab_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        cyc(1);
        rst     = 1'b0;
        mem_gnt = 1'b1;
        cyc(2);
        chk("ab_idle", 32'(busy), 32'd0);
        begin_frame(3, 2, 'h100);
        wait_done(400);
        chk("ab_pix", 32'(pix_cnt), 32'd6);
        chk("ab_gnt6", 32'(gnt_cnt), 32'd6);
        chk("ab_upd", 32'(upd_cnt), 32'd5);

`ifdef PIXEL_FETCH_STATS_EN
        begin
            int k;
            mem_gnt  = 1'b0;
            px_ready = 1'b0;
            begin_frame(2, 1, 'h020);
            k = 0;
            while (!mem_req && k < 20) begin
                cyc(1);
                k++;
            end
            cyc(5);
            mem_gnt = 1'b1;
            k = 0;
            while (!px_valid && k < 20) begin
                cyc(1);
                k++;
            end
            cyc(7);
            px_ready = 1'b1;
            wait_done(100);
            chk("stall_cycles", 32'(stall_cycles), 32'd5);
            chk("bp_cycles", 32'(bp_cycles), 32'd7);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
